benchmark_pio_arbiter: RTL
==========================

Name: benchmark_pio_arbiter

Overview:
Shares the 8-bit benchmark PIO output register between NUM_REQ independent requesters, such as PCP software timing hooks and hardware event sources. Each requester posts a write, set-bits or clear-bits operation with a req/ack handshake. The block serializes the operations with round-robin fairness into single Avalon-MM writes on the PIO slave: address 0 for direct write, address 4 for bit-set, address 5 for bit-clear. It also keeps a shadow copy of the PIO output and counts issued writes for debug.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
CNT_W, 16, width of the issued-write counter.

Ports:
clk  in  1  system clock; single clock domain.
reset_n  in  1  reset, asynchronous and active-low.
req_valid  in  NUM_REQ  per-requester request; held high until the matching ack.
req_op  in  2*NUM_REQ  per-requester op, 2 bits each: 00 write, 01 set, 10 clear, 11 reserved.
req_data  in  8*NUM_REQ  per-requester operand byte.
req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
req_err  out  1  one-cycle pulse, coincident with req_ack, when the op was reserved.
avm_address  out  3  PIO slave address.
avm_chipselect  out  1  PIO chipselect.
avm_write_n  out  1  PIO write strobe, active-low.
avm_writedata  out  32  {24'b0, operand}.
avm_waitrequest  in  1  slave stall; tie to 0 for the plain PIO.
shadow_out  out  8  mirror of the PIO data register after every accepted write.
busy  out  1  high whenever the FSM is not in IDLE.
write_count  out  CNT_W  number of accepted PIO writes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM returns to IDLE.
  - req_ack=0, req_err=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - shadow_out=0, which matches the PIO reset value.
  - write_count=0, busy=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction aborts the transaction with no ack; requesters must re-present.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If any req_valid bit is set, pick the winner as the first set bit searching upward from last_grant+1 with wrap.
  - Latch the winner index, op and data into registers; update last_grant to the winner.
  - If op=11, go to ACK with err flagged. Otherwise go to WRITE.
- WRITE:
  - Drive avm_chipselect=1 and avm_write_n=0.
  - avm_address: 0 for op 00, 4 for op 01, 5 for op 10.
  - avm_writedata = {24'b0, latched data}. All outputs come from registers and stay stable while avm_waitrequest=1.
  - On the cycle avm_waitrequest=0, the write is accepted:
    - shadow_out updates to data for write, shadow|data for set, shadow&~data for clear.
    - write_count increments.
    - Go to ACK.
- ACK:
  - Drive the Avalon bus idle (chipselect=0, write_n=1).
  - Pulse req_ack[winner]=1; pulse req_err if the op was reserved.
  - Go to IDLE. No new request is sampled in this cycle.
- Latency with waitrequest=0: request sampled in cycle N, write on the bus in N+1, ack in N+2. Minimum 3 cycles per op.
- Requesters drop req_valid or present a new op no earlier than the cycle after ack. A requester holding valid through the ack cycle is treated as a new request.
- Inputs of non-granted requesters are ignored until they win. Their req_op and req_data may change freely while not granted.
- Fairness: with all requesters continuously active, the grant order is 0,1,..,NUM_REQ-1,0,...
- Only one transaction is ever outstanding. shadow_out equals the PIO out_port whenever the arbiter is the sole master.
- write_count wrap: 0xFFFF + 1 -> 0x0000, with no flag.

Test Plan:
- Reset, then req0 op=00 data=0xA5 -> one write at addr 0 with writedata=0x000000A5 in cycle N+1; ack0 in N+2; shadow_out=0xA5; write_count=1.
- shadow=0xA5, req1 set 0x0A then req2 clear 0x21 -> writes at addr 4 then addr 5; shadow_out 0xAF then 0x8E; write_count=3.
- All four requesters held valid from reset, ops distinct -> grants in order 0,1,2,3; the second pass repeats 0,1,2,3; each ack arrives 3 cycles apart.
- req3 op=11 data=0xFF -> no chipselect; ack3 together with req_err one cycle after sampling; shadow and count unchanged.
- avm_waitrequest held high 5 cycles during a set 0x80 -> address, data and strobes constant for 6 cycles; the shadow update and ack occur only after release.
- reset_n pulsed low in WRITE mid-stall -> bus idle immediately; no ack; shadow=0; next grant goes to req0.

Source files
------------

// File: rtl/benchmark_pio_arbiter.sv
// Round-robin arbiter that serializes per-requester write/set/clear operations
// into single Avalon-MM writes on the benchmark PIO, with a shadow copy of the PIO output.
module benchmark_pio_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   req_err,
    output logic [2:0]             avm_address,
    output logic                   avm_chipselect,
    output logic                   avm_write_n,
    output logic [31:0]            avm_writedata,
    input  logic                   avm_waitrequest,
    output logic [7:0]             shadow_out,
    output logic                   busy,
    output logic [CNT_W-1:0]       write_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        ACK   = 2'b10
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       grant_reg, grant_next;
    logic [IDX_W-1:0]       last_grant_reg, last_grant_next;
    logic [1:0]             op_reg, op_next;
    logic [7:0]             data_reg, data_next;
    logic [7:0]             shadow_reg, shadow_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic [NUM_REQ-1:0]     ack_reg, ack_next;
    logic                   err_reg, err_next;
    logic                   cs_reg, cs_next;
    logic                   wn_reg, wn_next;
    logic [2:0]             addr_reg, addr_next;
    logic [31:0]            wdata_reg, wdata_next;

    logic [1:0]             op_arr   [NUM_REQ];
    logic [7:0]             data_arr [NUM_REQ];
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi]   = req_op[2*gi +: 2];
            assign data_arr[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return IDX_W'(sum % NUM_REQ);
    endfunction

    function automatic logic [2:0] op_address(input logic [1:0] op);
        logic [2:0] addr;
        case (op)
            OP_SET:   addr = 3'd4;
            OP_CLEAR: addr = 3'd5;
            default:  addr = 3'd0;
        endcase
        return addr;
    endfunction

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && req_valid[rr_index(last_grant_reg, i)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(last_grant_reg, i);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        op_next         = op_reg;
        data_next       = data_reg;
        shadow_next     = shadow_reg;
        count_next      = count_reg;
        ack_next        = '0;
        err_next        = 1'b0;
        cs_next         = cs_reg;
        wn_next         = wn_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;

        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    grant_next      = win_idx;
                    last_grant_next = win_idx;
                    op_next         = op_arr[win_idx];
                    data_next       = data_arr[win_idx];
                    if (op_arr[win_idx] == OP_RSVD) begin
                        // Reserved ops never touch the bus; complete with an error flag.
                        state_next        = ACK;
                        ack_next[win_idx] = 1'b1;
                        err_next          = 1'b1;
                    end else begin
                        state_next = WRITE;
                        cs_next    = 1'b1;
                        wn_next    = 1'b0;
                        addr_next  = op_address(op_arr[win_idx]);
                        wdata_next = {24'h0, data_arr[win_idx]};
                    end
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    case (op_reg)
                        OP_WRITE: shadow_next = data_reg;
                        OP_SET:   shadow_next = shadow_reg | data_reg;
                        OP_CLEAR: shadow_next = shadow_reg & ~data_reg;
                        default:  shadow_next = shadow_reg;
                    endcase
                    count_next          = count_reg + CNT_W'(1);
                    cs_next             = 1'b0;
                    wn_next             = 1'b1;
                    addr_next           = 3'd0;
                    wdata_next          = 32'h0;
                    ack_next[grant_reg] = 1'b1;
                    state_next          = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= LAST_IDX;
            op_reg         <= 2'b00;
            data_reg       <= 8'h00;
            shadow_reg     <= 8'h00;
            count_reg      <= '0;
            ack_reg        <= '0;
            err_reg        <= 1'b0;
            cs_reg         <= 1'b0;
            wn_reg         <= 1'b1;
            addr_reg       <= 3'd0;
            wdata_reg      <= 32'h0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            op_reg         <= op_next;
            data_reg       <= data_next;
            shadow_reg     <= shadow_next;
            count_reg      <= count_next;
            ack_reg        <= ack_next;
            err_reg        <= err_next;
            cs_reg         <= cs_next;
            wn_reg         <= wn_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
        end
    end

    assign req_ack        = ack_reg;
    assign req_err        = err_reg;
    assign avm_address    = addr_reg;
    assign avm_chipselect = cs_reg;
    assign avm_write_n    = wn_reg;
    assign avm_writedata  = wdata_reg;
    assign shadow_out     = shadow_reg;
    assign write_count    = count_reg;
    assign busy           = (state_reg != IDLE);

endmodule
